packed_field_packer: RTL and testbench
======================================

PACKED_FIELD_PACKER -- requirements
Module: packed_field_packer

Interface
REQ-001 SHALL have parameter FIELD_W, default 4, giving the bits per field.
REQ-002 SHALL have parameter NUM_FIELDS, default 2, giving the fields per output word.
REQ-003 SHALL have parameter MSB_FIRST, default 1: 1 places the first-received field in the most-significant slot, matching packed-struct declaration order; 0 places it in the least-significant slot.
REQ-004 SHALL have one clock; reset is asynchronous and active-low. Ports as follows.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  in_field is valid this cycle.
REQ-008 in_ready  output  1  packer accepts in_field this cycle.
REQ-009 in_field  input  FIELD_W  field value.
REQ-010 in_last  input  1  accepted field ends the word early.
REQ-011 out_valid  output  1  out_word is valid.
REQ-012 out_ready  input  1  consumer takes out_word this cycle.
REQ-013 out_word  output  FIELD_W*NUM_FIELDS  packed word.
REQ-014 out_count  output  $clog2(NUM_FIELDS+1)  number of fields loaded into out_word.

Function
REQ-015 SHALL define a field as accepted when in_valid and in_ready are both 1 on a rising clk edge; a word as drained when out_valid and out_ready are both 1.
REQ-016 SHALL use two states: FILL (assembling a word) and HOLD (word presented).
REQ-017 In FILL, SHALL drive in_ready=1 and out_valid=0.
REQ-018 In FILL, an accepted field SHALL be written to slot idx and idx SHALL increment. Slot idx occupies bits [(NUM_FIELDS-1-idx)*FIELD_W +: FIELD_W] when MSB_FIRST=1, else [idx*FIELD_W +: FIELD_W].
REQ-019 SHALL transition FILL->HOLD on the edge that accepts the field with idx==NUM_FIELDS-1, or any field with in_last=1; out_valid SHALL rise the following cycle (latency 1 from the final accept).
REQ-020 Slots not written before the transition SHALL read 0 in out_word; out_count SHALL equal the number of fields accepted for that word (1..NUM_FIELDS).
REQ-021 In HOLD, out_word and out_count SHALL stay stable while out_ready=0, and in_ready SHALL be 0.
REQ-022 In HOLD, SHALL drive in_ready=out_ready, so a drain and a new field accept can happen on the same edge.
REQ-023 On a drain with no simultaneous accept, SHALL go to FILL with idx=0, word cleared and out_count=0.
REQ-024 On a drain with a simultaneous accept, the new field SHALL become slot 0 of a cleared word with idx=1. If NUM_FIELDS==1 or in_last=1, the packer SHALL remain in HOLD with the new word (back-to-back words, no bubble).
REQ-025 With NUM_FIELDS==1, every accepted field SHALL produce one word with out_count=1.
REQ-026 in_last SHALL be ignored unless the field is accepted.
REQ-027 in_field and in_last SHALL be don't-care when in_valid=0; the packer SHALL NOT change state on them.
REQ-028 All outputs SHALL be driven from registers or from state only; there SHALL be no combinational path from in_field to out_word.

Reset
REQ-029 While rst_n=0, SHALL hold state=FILL, idx=0, out_word=0, out_count=0 and out_valid=0; in_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-030 Reset asserted mid-word SHALL discard all partial fields; the next accepted field after release SHALL be slot 0.

Structure
REQ-031 Shared package pfp_pkg SHALL hold the state enum typedef (FILL, HOLD) and a default-geometry packed struct typedef nib_pair_t {lo[3:0], hi[3:0]}.
REQ-032 SHALL be a single module with no sub-modules; slot placement SHALL be a generate-selected indexed part-select.
REQ-033 SHALL check at elaboration that FIELD_W>=1 and NUM_FIELDS>=1, and SHALL raise a fatal error otherwise.

Verification
REQ-034 Defaults: accept 4'h5 then 4'ha, out_ready=1 -> out_word=8'h5a, out_count=2, cast to nib_pair_t gives lo=5, hi=a.
REQ-035 MSB_FIRST=0: accept 4'h5 then 4'ha -> out_word=8'ha5.
REQ-036 Defaults: accept 4'h5 with in_last=1 -> out_word=8'h50, out_count=1, out_valid one cycle after accept.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles after word 8'h12 -> word stable, in_ready=0. Then out_ready=1 with in_field=4'h3 valid -> 8'h12 drains and 4'h3 is accepted on the same edge; next field 4'h4 -> 8'h34.
REQ-038 Reset mid-fill: accept 4'h7, pulse rst_n low, then accept 4'h1, 4'h2 -> out_word=8'h12, never 8'h7x.
REQ-039 FIELD_W=8, NUM_FIELDS=4: accept 8'h11, 8'h22, 8'h33, 8'h44 -> out_word=32'h11223344, out_count=4.

Source files
------------

// File: rtl/pfp_pkg.sv
// Shared types for the field packer: FSM state encoding and the default
// two-nibble word layout.
package pfp_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pfp_state_t;

  // Declaration order matches MSB_FIRST=1: first field received lands in 'lo'.
  typedef struct packed {
    logic [3:0] lo;
    logic [3:0] hi;
  } nib_pair_t;

  localparam int PFP_FIELD_W_DEF    = 4;
  localparam int PFP_NUM_FIELDS_DEF = 2;

endpackage

// File: rtl/packed_field_packer.sv
// Packs a stream of FIELD_W-bit fields into NUM_FIELDS-slot words, with
// early termination on in_last and same-edge drain/accept in HOLD.
//
// state | meaning
// FILL  | assembling a word, in_ready=1, out_valid=0
// HOLD  | word presented on out_word, in_ready follows out_ready
module packed_field_packer
  import pfp_pkg::*;
#(
  parameter int FIELD_W    = PFP_FIELD_W_DEF,
  parameter int NUM_FIELDS = PFP_NUM_FIELDS_DEF,
  parameter int MSB_FIRST  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [FIELD_W-1:0]                    in_field,
  input  logic                                  in_last,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [FIELD_W*NUM_FIELDS-1:0]         out_word,
  output logic [$clog2(NUM_FIELDS+1)-1:0]       out_count
);

  localparam int WORD_W = FIELD_W * NUM_FIELDS;
  localparam int CNT_W  = $clog2(NUM_FIELDS + 1);

  if ((FIELD_W < 1) || (NUM_FIELDS < 1)) begin : g_bad_param
    $fatal(1, "packed_field_packer: FIELD_W and NUM_FIELDS must both be >= 1");
  end

  pfp_state_t        r_state;
  pfp_state_t        w_state_nxt;
  logic              r_run;
  logic [CNT_W-1:0]  r_idx;
  logic [CNT_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0]  w_base_idx;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word_nxt;
  logic [WORD_W-1:0] w_base_word;
  logic [WORD_W-1:0] w_slot_word;
  int                w_slot_lo;
  logic              w_accept;
  logic              w_drain;
  logic              w_last_slot;

  assign out_valid = (r_state == HOLD);
  assign in_ready  = r_run & ((r_state == FILL) | out_ready);
  assign out_word  = r_word;
  assign out_count = r_idx;

  assign w_accept = in_valid & in_ready;
  assign w_drain  = out_valid & out_ready;

  // An accept in HOLD always coincides with a drain, so it starts a fresh word.
  assign w_base_idx  = (r_state == HOLD) ? '0 : r_idx;
  assign w_base_word = (r_state == HOLD) ? '0 : r_word;
  assign w_last_slot = (int'(w_base_idx) == NUM_FIELDS - 1);

  if (MSB_FIRST != 0) begin : g_msb_first
    assign w_slot_lo = (NUM_FIELDS - 1 - int'(w_base_idx)) * FIELD_W;
  end else begin : g_lsb_first
    assign w_slot_lo = int'(w_base_idx) * FIELD_W;
  end

  always_comb begin
    w_slot_word = w_base_word;
    w_slot_word[w_slot_lo +: FIELD_W] = in_field;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_word_nxt  = r_word;
    if (w_accept) begin
      w_word_nxt  = w_slot_word;
      w_idx_nxt   = w_base_idx + CNT_W'(1);
      w_state_nxt = (w_last_slot || in_last) ? HOLD : FILL;
    end else if (w_drain) begin
      w_word_nxt  = '0;
      w_idx_nxt   = '0;
      w_state_nxt = FILL;
    end
  end

  // r_run keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_run   <= 1'b0;
      r_idx   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      r_idx   <= w_idx_nxt;
      r_word  <= w_word_nxt;
    end
  end

endmodule

// File: tb/tb_packed_field_packer.sv
// Bench for packed_field_packer: four geometries share one stimulus stream,
// each compared every cycle against a queue-based word model.
module tb_packed_field_packer;
  import pfp_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_field = 8'h0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;

  logic        o_rdy [4];
  logic        o_vld [4];
  logic [31:0] o_word [4];
  logic [31:0] o_cnt [4];

  logic [7:0]  word0, word1;
  logic [31:0] word2;
  logic [3:0]  word3;
  logic [1:0]  cnt0, cnt1;
  logic [2:0]  cnt2;
  logic        cnt3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packed_field_packer #(.FIELD_W(4), .NUM_FIELDS(2), .MSB_FIRST(1)) u_def (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
    .in_field(in_field[3:0]), .in_last(in_last), .out_valid(o_vld[0]),
    .out_ready(out_ready), .out_word(word0), .out_count(cnt0));

  packed_field_packer #(.FIELD_W(4), .NUM_FIELDS(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
    .in_field(in_field[3:0]), .in_last(in_last), .out_valid(o_vld[1]),
    .out_ready(out_ready), .out_word(word1), .out_count(cnt1));

  packed_field_packer #(.FIELD_W(8), .NUM_FIELDS(4), .MSB_FIRST(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[2]),
    .in_field(in_field), .in_last(in_last), .out_valid(o_vld[2]),
    .out_ready(out_ready), .out_word(word2), .out_count(cnt2));

  packed_field_packer #(.FIELD_W(4), .NUM_FIELDS(1), .MSB_FIRST(1)) u_one (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[3]),
    .in_field(in_field[3:0]), .in_last(in_last), .out_valid(o_vld[3]),
    .out_ready(out_ready), .out_word(word3), .out_count(cnt3));

  assign o_word[0] = {24'h0, word0};
  assign o_word[1] = {24'h0, word1};
  assign o_word[2] = word2;
  assign o_word[3] = {28'h0, word3};
  assign o_cnt[0]  = {30'h0, cnt0};
  assign o_cnt[1]  = {30'h0, cnt1};
  assign o_cnt[2]  = {29'h0, cnt2};
  assign o_cnt[3]  = {31'h0, cnt3};

  // Reference model: fields queue up until the word is full or in_last,
  // then the whole word is presented until the consumer takes it.
  int          cfg_fw  [4] = '{4, 4, 8, 4};
  int          cfg_nf  [4] = '{2, 2, 4, 1};
  int          cfg_msb [4] = '{1, 0, 1, 1};
  bit          m_run   [4];
  bit          m_held  [4];
  logic [31:0] m_word  [4];
  int          m_cnt   [4];
  int          m_parts [4][$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(int k);
    return m_run[k] && (!m_held[k] || out_ready);
  endfunction

  function automatic logic [31:0] model_pack(int k);
    logic [31:0] w;
    int pos;
    w = '0;
    for (int i = 0; i < m_parts[k].size(); i++) begin
      pos = (cfg_msb[k] != 0) ? (cfg_nf[k] - 1 - i) : i;
      w = w | (32'(m_parts[k][i]) << (pos * cfg_fw[k]));
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_run[k]  = 1'b0;
      m_held[k] = 1'b0;
      m_word[k] = '0;
      m_cnt[k]  = 0;
      m_parts[k].delete();
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] f, input bit l, input bit r);
    bit acc, drn;
    int mask;
    for (int k = 0; k < 4; k++) begin
      acc  = v && exp_ready(k);
      drn  = m_held[k] && r;
      mask = (1 << cfg_fw[k]) - 1;
      if (drn) m_held[k] = 1'b0;
      if (acc) begin
        m_parts[k].push_back(int'(f) & mask);
        if (m_parts[k].size() == cfg_nf[k] || l) begin
          m_word[k] = model_pack(k);
          m_cnt[k]  = m_parts[k].size();
          m_held[k] = 1'b1;
          m_parts[k].delete();
        end
      end
      m_run[k] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("in_ready[%0d]", k), 32'(o_rdy[k]), 32'(exp_ready(k)));
      chk($sformatf("out_valid[%0d]", k), 32'(o_vld[k]), 32'(m_held[k]));
      if (m_held[k]) begin
        chk($sformatf("out_word[%0d]", k), o_word[k], m_word[k]);
        chk($sformatf("out_count[%0d]", k), o_cnt[k], 32'(m_cnt[k]));
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [7:0] f, input bit l, input bit r);
    in_valid  = v;
    in_field  = f;
    in_last   = l;
    out_ready = r;
    #1;
    check_all();
    model_edge(v, f, l, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_in_ready[%0d]", k), 32'(o_rdy[k]), 32'h0);
      chk($sformatf("rst_out_valid[%0d]", k), 32'(o_vld[k]), 32'h0);
      chk($sformatf("rst_out_word[%0d]", k), o_word[k], 32'h0);
      chk($sformatf("rst_out_count[%0d]", k), o_cnt[k], 32'h0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  nib_pair_t np;
  bit        rv, rl, rr;
  logic [7:0] rf;

  initial begin
    model_reset();
    @(negedge clk);
    apply_reset();
    step(0, 8'h00, 0, 1);

    // Default and LSB-first placement of 5 then a
    step(1, 8'h05, 0, 1);
    step(1, 8'h0a, 0, 1);
    chk("req034_word", {24'h0, word0}, 32'h5a);
    chk("req034_count", {30'h0, cnt0}, 32'h2);
    np = nib_pair_t'(word0);
    chk("req034_lo", {28'h0, np.lo}, 32'h5);
    chk("req034_hi", {28'h0, np.hi}, 32'ha);
    chk("req035_word", {24'h0, word1}, 32'ha5);
    step(0, 8'h00, 0, 1);

    // Early termination with in_last
    step(1, 8'h05, 1, 1);
    chk("req036_valid", 32'(o_vld[0]), 32'h1);
    chk("req036_word", {24'h0, word0}, 32'h50);
    chk("req036_count", {30'h0, cnt0}, 32'h1);
    step(0, 8'h00, 0, 1);

    // Backpressure, then drain and accept on the same edge
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'hff, 1, 0);
      chk("req037_hold_word", {24'h0, word0}, 32'h12);
      chk("req037_hold_ready", 32'(o_rdy[0]), 32'h0);
    end
    step(1, 8'h03, 0, 1);
    chk("req037_after_drain_count", {30'h0, cnt0}, 32'h1);
    step(1, 8'h04, 0, 1);
    chk("req037_word", {24'h0, word0}, 32'h34);
    step(0, 8'h00, 0, 1);

    // Reset mid-word discards the partial field
    step(1, 8'h07, 0, 1);
    apply_reset();
    step(0, 8'h00, 0, 1);
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);
    chk("req038_word", {24'h0, word0}, 32'h12);

    // Wide geometry
    apply_reset();
    step(0, 8'h00, 0, 1);
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1);
    step(1, 8'h44, 0, 1);
    chk("req039_word", word2, 32'h11223344);
    chk("req039_count", {29'h0, cnt2}, 32'h4);
    step(0, 8'h00, 0, 1);

    // Random traffic with backpressure, in_last and an occasional reset
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rf = 8'($urandom);
      rl = ($urandom_range(0, 4) == 0);
      rr = ($urandom_range(0, 3) != 0);
      if (i == 200) apply_reset();
      step(rv, rf, rl, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
